// File: rtl/vita_frame_reframer.sv
// Length-driven reframer: reads the header length of a flagless word stream and re-emits it
// with {occ, eof, sof} flags through a registered output stage. Define REFRAMER_STATS_EN to build counters.
module vita_frame_reframer #(
  parameter int WIDTH     = 16,
  parameter int LEN_BITS  = 15,
  parameter int LEN_SHIFT = 1,
  parameter int MAX_LEN   = 2048
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [WIDTH-1:0] data_i,
  input  logic             src_rdy_i,
  output logic             dst_rdy_o,
  output logic [WIDTH+2:0] data_o,
  output logic             src_rdy_o,
  input  logic             dst_rdy_i,
  output logic [1:0]       state,
  output logic             err_pulse,
  output logic [31:0]      pkt_count,
  output logic [15:0]      err_count
);

  localparam int LW = LEN_BITS + LEN_SHIFT;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PKT  = 2'd1
  } state_t;

  state_t        st;
  logic [LW-1:0] rem;
  logic [LW-1:0] len;
  logic          acc_i;
  logic          acc_o;
  logic          len_bad;
  logic          err_hit;
  logic          out_sof;
  logic          out_eof;

  assign acc_i     = src_rdy_i & dst_rdy_o;
  assign acc_o     = src_rdy_o & dst_rdy_i;
  // The output register refills in the same cycle it drains, so a stalled-but-draining stage still accepts.
  assign dst_rdy_o = ~src_rdy_o | dst_rdy_i;
  assign state     = st;

  // Widen before shifting so the header length never truncates.
  assign len     = LW'(data_i[LEN_BITS-1:0]) << LEN_SHIFT;
  assign len_bad = (len == '0) || (32'(len) > 32'(MAX_LEN));
  assign err_hit = acc_i && (st == IDLE) && len_bad;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    out_sof = 1'b0;
    out_eof = 1'b0;
    if (st == IDLE) begin
      out_sof = 1'b1;
      out_eof = len_bad || (len == LW'(1));
    end else begin
      out_eof = (rem == LW'(1));
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st        <= IDLE;
      rem       <= '0;
      src_rdy_o <= 1'b0;
      data_o    <= '0;
      err_pulse <= 1'b0;
    end else if (clear) begin
      st        <= IDLE;
      rem       <= '0;
      src_rdy_o <= 1'b0;
      data_o    <= '0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= err_hit;
      if (acc_i) begin
        data_o    <= {1'b0, out_eof, out_sof, data_i};
        src_rdy_o <= 1'b1;
        case (st)
          IDLE: begin
            // Illegal headers stay in IDLE so the very next word is taken as a header.
            if (!len_bad && (len != LW'(1))) begin
              rem <= len - LW'(1);
              st  <= PKT;
            end
          end
          PKT: begin
            rem <= rem - LW'(1);
            if (rem == LW'(1)) st <= IDLE;
          end
          default: st <= IDLE;
        endcase
      end else if (acc_o) begin
        src_rdy_o <= 1'b0;
      end
    end
  end

`ifdef REFRAMER_STATS_EN
  logic pkt_done;

  assign pkt_done = acc_i && out_eof && !err_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pkt_count <= '0;
      err_count <= '0;
    end else if (clear) begin
      pkt_count <= '0;
      err_count <= '0;
    end else begin
      if (pkt_done) pkt_count <= pkt_count + 32'd1;
      if (err_hit && (err_count != 16'hFFFF)) err_count <= err_count + 16'd1;
    end
  end
`else
  assign pkt_count = '0;
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_vita_frame_reframer.sv
// Bench for vita_frame_reframer: header table, packet-level reference model with random
// gaps/stalls, clear/reset corner cases, and a 32-bit instance.
module tb_vita_frame_reframer;

`ifdef REFRAMER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic [15:0] data_i;
  logic        src_rdy_i;
  logic        dst_rdy_i;
  logic        dst_rdy_o;
  logic [18:0] data_o;
  logic        src_rdy_o;
  logic [1:0]  state;
  logic        err_pulse;
  logic [31:0] pkt_count;
  logic [15:0] err_count;

  logic [31:0] data_i32;
  logic        src_rdy_i32;
  logic        dst_rdy_o32;
  logic [34:0] data_o32;
  logic        src_rdy_o32;
  logic [1:0]  state32;
  logic        err_pulse32;
  logic [31:0] pkt_count32;
  logic [15:0] err_count32;

  always #5 clk = ~clk;

  vita_frame_reframer u_dut (
    .clk(clk), .reset(reset), .clear(clear), .data_i(data_i), .src_rdy_i(src_rdy_i),
    .dst_rdy_o(dst_rdy_o), .data_o(data_o), .src_rdy_o(src_rdy_o), .dst_rdy_i(dst_rdy_i),
    .state(state), .err_pulse(err_pulse), .pkt_count(pkt_count), .err_count(err_count)
  );

  vita_frame_reframer #(.WIDTH(32), .LEN_BITS(15), .LEN_SHIFT(0), .MAX_LEN(2048)) u_dut32 (
    .clk(clk), .reset(reset), .clear(clear), .data_i(data_i32), .src_rdy_i(src_rdy_i32),
    .dst_rdy_o(dst_rdy_o32), .data_o(data_o32), .src_rdy_o(src_rdy_o32), .dst_rdy_i(1'b1),
    .state(state32), .err_pulse(err_pulse32), .pkt_count(pkt_count32), .err_count(err_count32)
  );

  typedef struct {
    logic [15:0] din;
    logic [18:0] exp_out;
    logic        exp_err;
    logic [1:0]  exp_state;
  } vec_t;

  vec_t        vecs[8];
  logic [15:0] stim_q[$];
  logic [18:0] exp_q[$];
  logic [18:0] got_q[$];
  int          m_pkts;
  int          m_errs;
  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [63:0] stats(input int v);
    return STATS ? 64'(v) : 64'd0;
  endfunction

  // Packet-level reference: walk headers, emit each packet's words with sof first and eof last.
  task automatic model();
    int i = 0;
    exp_q.delete();
    m_pkts = 0;
    m_errs = 0;
    while (i < stim_q.size()) begin
      logic [15:0] hdr = stim_q[i];
      int len = int'(hdr[14:0]) * 2;
      if (len == 0 || len > 2048) begin
        exp_q.push_back({1'b0, 1'b1, 1'b1, hdr});
        m_errs++;
        i++;
      end else begin
        int start = i;
        for (int k = 0; k < len && i < stim_q.size(); k++) begin
          exp_q.push_back({1'b0, 1'(k == len - 1), 1'(k == 0), stim_q[i]});
          i++;
        end
        if (i - start == len) m_pkts++;
      end
    end
  endtask

  // Feeds stim_q with random valid gaps and downstream stalls; collects accepted outputs.
  task automatic run_stream(input int gap_pct, input int stall_pct, output int cycles);
    int idx = 0, pulses = 0, hs_bad = 0, hold_bad = 0;
    int limit = 20 * stim_q.size() + 100;
    logic hold = 1'b0, acc_in;
    logic [18:0] held = '0;
    cycles = 0;
    got_q.delete();
    while ((idx < stim_q.size() || src_rdy_o) && cycles < limit) begin
      if (err_pulse) pulses++;
      if (hold && (!src_rdy_o || data_o !== held)) hold_bad++;
      src_rdy_i = (idx < stim_q.size()) && ($urandom_range(0, 99) >= gap_pct);
      data_i    = src_rdy_i ? stim_q[idx] : 16'($urandom);
      dst_rdy_i = ($urandom_range(0, 99) >= stall_pct);
      #1;
      if (dst_rdy_o !== (!src_rdy_o || dst_rdy_i)) hs_bad++;
      acc_in = src_rdy_i && dst_rdy_o;
      if (src_rdy_o && dst_rdy_i) got_q.push_back(data_o);
      hold = src_rdy_o && !dst_rdy_i;
      held = data_o;
      @(posedge clk);
      if (acc_in) idx++;
      cycles++;
      @(negedge clk);
    end
    src_rdy_i = 1'b0;
    dst_rdy_i = 1'b1;
    check("stream_timeout", 64'(cycles < limit), 64'd1);
    model();
    check("out_count", 64'(got_q.size()), 64'(exp_q.size()));
    for (int j = 0; j < exp_q.size() && j < got_q.size(); j++)
      check($sformatf("word%0d", j), 64'(got_q[j]), 64'(exp_q[j]));
    check("err_pulses", 64'(pulses), 64'(m_errs));
    check("handshake_rule", 64'(hs_bad), 64'd0);
    check("stall_hold", 64'(hold_bad), 64'd0);
  endtask

  task automatic drive_word(input logic [15:0] d);
    data_i    = d;
    src_rdy_i = 1'b1;
    dst_rdy_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    src_rdy_i = 1'b0;
  endtask

  task automatic drive32(input logic [31:0] d);
    data_i32    = d;
    src_rdy_i32 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    src_rdy_i32 = 1'b0;
  endtask

  task automatic do_clear();
    clear     = 1'b1;
    src_rdy_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    vecs[0] = '{16'h0000, 19'h30000, 1'b1, 2'd0};
    vecs[1] = '{16'h8000, 19'h38000, 1'b1, 2'd0};
    vecs[2] = '{16'h7FFF, 19'h37FFF, 1'b1, 2'd0};
    vecs[3] = '{16'h0401, 19'h30401, 1'b1, 2'd0};
    vecs[4] = '{16'h0001, 19'h10001, 1'b0, 2'd1};
    vecs[5] = '{16'hBEEF, 19'h2BEEF, 1'b0, 2'd0};
    vecs[6] = '{16'h8001, 19'h18001, 1'b0, 2'd1};
    vecs[7] = '{16'h0000, 19'h20000, 1'b0, 2'd0};

    reset = 1'b1; clear = 1'b0;
    data_i = '0; src_rdy_i = 1'b0; dst_rdy_i = 1'b1;
    data_i32 = '0; src_rdy_i32 = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_state", 64'(state), 64'd0);
    check("rst_src_rdy", 64'(src_rdy_o), 64'd0);
    check("rst_data", 64'(data_o), 64'd0);
    check("rst_err_pulse", 64'(err_pulse), 64'd0);
    check("rst_pkt_count", 64'(pkt_count), 64'd0);
    check("rst_err_count", 64'(err_count), 64'd0);
    check("rst_dst_rdy", 64'(dst_rdy_o), 64'd1);
    check("rst_state32", 64'(state32), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Header table: errors, resync after an over-length header, 2-word packets.
    for (int i = 0; i < 8; i++) begin
      drive_word(vecs[i].din);
      check($sformatf("tbl%0d_data", i), 64'(data_o), 64'(vecs[i].exp_out));
      check($sformatf("tbl%0d_err", i), 64'(err_pulse), 64'(vecs[i].exp_err));
      check($sformatf("tbl%0d_state", i), 64'(state), 64'(vecs[i].exp_state));
    end
    check("tbl_pkt_count", 64'(pkt_count), stats(2));
    check("tbl_err_count", 64'(err_count), stats(4));

    // 6-word packet at full rate, then the same packet with gaps and stalls.
    do_clear();
    stim_q = '{16'h0003, 16'hA001, 16'hA002, 16'hA003, 16'hA004, 16'hA005};
    run_stream(0, 0, cyc);
    check("full_rate_cycles", 64'(cyc), 64'd7);
    check("t1_state", 64'(state), 64'd0);
    check("t1_pkt_count", 64'(pkt_count), stats(1));
    do_clear();
    run_stream(30, 50, cyc);
    check("t2_pkt_count", 64'(pkt_count), stats(1));

    // Random packet mix against the reference model.
    do_clear();
    stim_q.delete();
    for (int p = 0; p < 40; p++) begin
      if ($urandom_range(0, 9) < 2) begin
        case ($urandom_range(0, 2))
          0: stim_q.push_back(16'h0000);
          1: stim_q.push_back(16'h8000);
          default: stim_q.push_back(16'(16'h0401 + $urandom_range(0, 100)));
        endcase
      end else begin
        int units = $urandom_range(1, 12);
        stim_q.push_back({1'($urandom_range(0, 1)), 15'(units)});
        for (int w = 0; w < 2 * units - 1; w++) stim_q.push_back(16'($urandom));
      end
    end
    run_stream(20, 30, cyc);
    check("rand_state", 64'(state), 64'd0);
    check("rand_pkt_count", 64'(pkt_count), stats(m_pkts));
    check("rand_err_count", 64'(err_count), stats(m_errs));

    // Largest legal packet: 2048 words.
    do_clear();
    stim_q.delete();
    stim_q.push_back(16'h0400);
    for (int w = 0; w < 2047; w++) stim_q.push_back(16'(w));
    run_stream(0, 0, cyc);
    check("max_pkt_count", 64'(pkt_count), stats(1));
    check("max_err_count", 64'(err_count), 64'd0);

    // Clear mid-packet, with a word offered in the clear cycle.
    do_clear();
    drive_word(16'h0004);
    for (int w = 0; w < 3; w++) drive_word(16'(16'hC000 + w));
    clear = 1'b1; src_rdy_i = 1'b1; data_i = 16'hDEAD; dst_rdy_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear = 1'b0; src_rdy_i = 1'b0;
    check("clr_src_rdy", 64'(src_rdy_o), 64'd0);
    check("clr_state", 64'(state), 64'd0);
    check("clr_data", 64'(data_o), 64'd0);
    stim_q = '{16'h0001, 16'h5555};
    run_stream(0, 0, cyc);
    check("clr_after_state", 64'(state), 64'd0);
    check("clr_pkt_count", 64'(pkt_count), stats(1));

    // Asynchronous reset mid-packet, asserted between clock edges.
    drive_word(16'h0002);
    drive_word(16'h1234);
    #2 reset = 1'b1;
    #1;
    check("arst_state", 64'(state), 64'd0);
    check("arst_src_rdy", 64'(src_rdy_o), 64'd0);
    check("arst_pkt_count", 64'(pkt_count), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    stim_q = '{16'h0001, 16'h1111};
    run_stream(10, 10, cyc);

    // 32-bit instance: len==1 single-word packets and length boundaries.
    drive32(32'h0000_0001);
    check("w32_single_data", 64'(data_o32), 64'({3'b011, 32'h0000_0001}));
    check("w32_single_state", 64'(state32), 64'd0);
    check("w32_pkt1", 64'(pkt_count32), stats(1));
    check("w32_err0", 64'(err_count32), 64'd0);
    drive32(32'h8000_0002);
    check("w32_hdr_data", 64'(data_o32), 64'({3'b001, 32'h8000_0002}));
    check("w32_hdr_state", 64'(state32), 64'd1);
    drive32(32'hCAFE_F00D);
    check("w32_eof_data", 64'(data_o32), 64'({3'b010, 32'hCAFE_F00D}));
    check("w32_pkt2", 64'(pkt_count32), stats(2));
    drive32(32'h0000_0801);
    check("w32_bad_data", 64'(data_o32), 64'({3'b011, 32'h0000_0801}));
    check("w32_bad_pulse", 64'(err_pulse32), 64'd1);
    check("w32_err1", 64'(err_count32), stats(1));
    drive32(32'h0000_0800);
    check("w32_max_state", 64'(state32), 64'd1);
    check("w32_max_pulse", 64'(err_pulse32), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
